// File: rtl/bus_move_ctrl_pkg.sv
// Shared sizes and FSM encoding for the register-move bus controller.
package bus_move_ctrl_pkg;
   localparam int NREG = 8;
   localparam int SELW = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_WRITE,
      S_DONE
   } state_t;
endpackage

// File: rtl/bus_move_ctrl_onehot_dec.sv
// Index-to-one-hot decoder with a gating enable.
module onehot_dec
   import bus_move_ctrl_pkg::*;
(
   input  logic [SELW-1:0] i_idx,
   input  logic            i_en,
   output logic [NREG-1:0] o_vec
);
   always_comb begin
      o_vec = '0;
      if (i_en) o_vec[i_idx] = 1'b1;
   end
endmodule

// File: rtl/bus_move_ctrl.sv
// Sequences one register-to-register or immediate move over a shared
// 8-bit tri-state bus: drive, latch, then report completion.
module bus_move_ctrl
   import bus_move_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            res,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [SELW-1:0] req_src,
   input  logic [SELW-1:0] req_dst,
   input  logic            req_imm,
   input  logic [7:0]      req_data,
   input  logic [7:0]      bus_in,
   output logic [NREG-1:0] load_en,
   output logic [NREG-1:0] save_en,
   output logic            imm_oe,
   output logic [7:0]      imm_byte,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [7:0]      last_byte
);
   state_t          r_state;
   state_t          w_next;
   logic [SELW-1:0] r_src;
   logic [SELW-1:0] r_dst;
   logic            r_imm;
   logic [7:0]      r_data;
   logic            r_err;
   logic [7:0]      r_last;
   logic            w_accept;
   logic            w_bad;
   logic            w_drive;
   logic            w_save;

   assign w_accept = req_valid && (r_state == S_IDLE);
   assign w_bad    = !req_imm && (req_src == req_dst);

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_imm   <= 1'b0;
         r_data  <= 8'h00;
         r_err   <= 1'b0;
         r_last  <= 8'h00;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_src  <= req_src;
            r_dst  <= req_dst;
            r_imm  <= req_imm;
            r_data <= req_data;
            r_err  <= w_bad;
         end
         if (r_state == S_WRITE) r_last <= bus_in;
      end
   end

   // Outputs decode from the registered state only, so an async
   // reset drops every enable without waiting for a clock edge.
   always_comb begin
      w_next  = r_state;
      w_drive = 1'b0;
      w_save  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid) w_next = w_bad ? S_DONE : S_DRIVE;
         end
         S_DRIVE: begin
            w_drive = 1'b1;
            w_next  = S_WRITE;
         end
         S_WRITE: begin
            w_drive = 1'b1;
            w_save  = 1'b1;
            w_next  = S_DONE;
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
      endcase
   end

   onehot_dec u_load_dec (
      .i_idx (r_src),
      .i_en  (w_drive && !r_imm),
      .o_vec (load_en)
   );

   onehot_dec u_save_dec (
      .i_idx (r_dst),
      .i_en  (w_save),
      .o_vec (save_en)
   );

   assign imm_oe    = w_drive && r_imm;
   assign imm_byte  = imm_oe ? r_data : 8'h00;
   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign err       = done && r_err;
   assign last_byte = r_last;
endmodule

// File: tb/tb_bus_move_ctrl.sv
// Scoreboard bench: a register-file model on the bus plus a
// transaction-level reference of each move's outcome and timing.
module tb_bus_move_ctrl;
   logic       clk;
   logic       res;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_src;
   logic [2:0] req_dst;
   logic       req_imm;
   logic [7:0] req_data;
   logic [7:0] bus_in;
   logic [7:0] load_en;
   logic [7:0] save_en;
   logic       imm_oe;
   logic [7:0] imm_byte;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] last_byte;

   bus_move_ctrl dut (
      .clk       (clk),
      .res       (res),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .req_imm   (req_imm),
      .req_data  (req_data),
      .bus_in    (bus_in),
      .load_en   (load_en),
      .save_en   (save_en),
      .imm_oe    (imm_oe),
      .imm_byte  (imm_byte),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .last_byte (last_byte)
   );

   typedef struct {
      int         t;
      bit         bad;
      bit         imm;
      logic [2:0] src;
      logic [2:0] dst;
      logic [7:0] data;
      logic [7:0] last;
      int         ndrv;
   } exp_t;

   exp_t       q[$];
   logic [7:0] env_reg[8];
   logic [7:0] mreg[8];
   logic [7:0] mlast;
   int         cyc;
   int         n_chk;
   int         n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Bench-side registers sharing the bus.
   always_comb begin
      bus_in = 8'h00;
      if (imm_oe) bus_in = imm_byte;
      for (int i = 0; i < 8; i++)
         if (load_en[i]) bus_in = env_reg[i];
   end

   always @(posedge clk)
      for (int i = 0; i < 8; i++)
         if (save_en[i]) env_reg[i] <= bus_in;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (res) begin
         n_chk++;
         if (req_ready !== !busy || !$onehot0(load_en) ||
             !$onehot0(save_en) || (|load_en && imm_oe) ||
             (!imm_oe && imm_byte != 8'h00) || (err && !done)) begin
            n_fail++;
            $display("FAIL invariant actual=ld%h sv%h oe%b ib%h rdy%b bsy%b required=consistent",
                     load_en, save_en, imm_oe, imm_byte, req_ready, busy);
         end
         if (|load_en || imm_oe || |save_en) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL stray_enable actual=ld%h sv%h oe%b required=idle",
                        load_en, save_en, imm_oe);
            end else begin
               exp_t e;
               logic [7:0] xs, xl;
               bit ok;
               e  = q[0];
               xs = (cyc == e.t + 2) ? (8'd1 << e.dst) : 8'd0;
               xl = e.imm ? 8'd0 : (8'd1 << e.src);
               ok = !e.bad && (cyc == e.t + 1 || cyc == e.t + 2) &&
                    load_en == xl && imm_oe == e.imm &&
                    (!e.imm || imm_byte == e.data) && save_en == xs;
               if (!ok) begin
                  n_fail++;
                  $display("FAIL drive actual=c%0d ld%h sv%h oe%b ib%h required=t%0d ld%h sv%h oe%b ib%h",
                           cyc, load_en, save_en, imm_oe, imm_byte,
                           e.t, xl, xs, e.imm, e.data);
               end
               q[0].ndrv++;
            end
         end
         if (done) begin
            if (q.size() == 0) begin
               chk("stray_done", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("done_cycle", cyc, e.t + (e.bad ? 1 : 3));
               chk("err", err, e.bad);
               chk("last_byte", last_byte, e.last);
               chk("drive_cycles", e.ndrv, e.bad ? 0 : 2);
            end
         end
      end
   end

   // Issues at a negedge; returns at the negedge after acceptance.
   task automatic do_req(input logic [2:0] s, input logic [2:0] d,
                         input logic im, input logic [7:0] dat,
                         input bit drop, output int t, output int waited);
      exp_t e;
      req_src   = s;
      req_dst   = d;
      req_imm   = im;
      req_data  = dat;
      req_valid = 1'b1;
      waited    = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) chk("accept_timeout", 0, 1);
      t      = cyc;
      e.t    = cyc;
      e.bad  = !im && (s == d);
      e.imm  = im;
      e.src  = s;
      e.dst  = d;
      e.data = dat;
      e.ndrv = 0;
      if (!e.bad) begin
         mlast   = im ? dat : mreg[s];
         mreg[d] = mlast;
      end
      e.last = mlast;
      q.push_back(e);
      @(negedge clk);
      if (drop) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q.size() != 0 || !req_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("done_timeout", q.size(), 0);
   endtask

   initial begin
      int t1, t2, w;
      logic [7:0] old;
      n_chk = 0; n_fail = 0; cyc = 0;
      res = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0;
      req_imm = 1'b0; req_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         env_reg[i] = 8'($urandom);
         mreg[i]    = env_reg[i];
      end
      env_reg[2] = 8'h3C;
      mreg[2]    = 8'h3C;
      mlast      = 8'h00;
      #1;
      chk("rst_load_en", load_en, 0);
      chk("rst_save_en", save_en, 0);
      chk("rst_imm", {imm_oe, imm_byte}, 0);
      chk("rst_flags", {busy, done, err}, 0);
      chk("rst_last", last_byte, 0);
      chk("rst_ready", req_ready, 1);
      repeat (2) @(negedge clk);
      res = 1'b1;

      do_req(3'd2, 3'd5, 1'b0, 8'h00, 1, t1, w);
      wait_idle();
      chk("move_last", last_byte, 8'h3C);

      do_req(3'd0, 3'd0, 1'b1, 8'hA5, 1, t1, w);
      wait_idle();
      chk("imm_last", last_byte, 8'hA5);

      do_req(3'd3, 3'd3, 1'b0, 8'h00, 1, t1, w);
      wait_idle();
      chk("err_last", last_byte, 8'hA5);

      do_req(3'd1, 3'd6, 1'b0, 8'h00, 0, t1, w);
      do_req(3'd4, 3'd7, 1'b1, 8'h5A, 1, t2, w);
      chk("b2b_gap", t2 - t1, 4);
      chk("b2b_wait", w, 3);
      wait_idle();

      do_req(3'd6, 3'd1, 1'b0, 8'h00, 0, t1, w);
      req_src  = 3'd0;
      req_dst  = 3'd4;
      req_imm  = 1'b1;
      req_data = 8'hEE;
      @(negedge clk);
      req_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);

      old = mreg[2];
      do_req(3'd5, 3'd2, 1'b0, 8'h00, 1, t1, w);
      @(negedge clk);
      chk("rstmid_save_before", save_en, 8'h04);
      res = 1'b0;
      #1;
      chk("rstmid_save", save_en, 0);
      chk("rstmid_load", {load_en, imm_oe, imm_byte}, 0);
      chk("rstmid_flags", {busy, done, err}, 0);
      chk("rstmid_last", last_byte, 0);
      chk("rstmid_ready", req_ready, 1);
      @(negedge clk);
      q.delete();
      mreg[2] = old;
      mlast   = 8'h00;
      res = 1'b1;
      do_req(3'd2, 3'd3, 1'b0, 8'h00, 1, t1, w);
      wait_idle();
      chk("post_rst_last", last_byte, mreg[3]);

      repeat (60) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_req(3'($urandom), 3'($urandom), ($urandom % 4) == 0,
                8'($urandom), 1, t1, w);
      end
      wait_idle();
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++)
         chk($sformatf("reg%0d", i), env_reg[i], mreg[i]);
      chk("final_last", last_byte, mlast);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
